pdp8_rfx: RTL

PDP8_RFX -- requirements
Module: pdp8_rfx

---
 rtl/pdp8_rfx_pkg.sv | 44 ++++
 rtl/pdp8_rfx_if.sv | 49 ++++
 rtl/pdp8_rfx_dma.sv | 183 ++++++++++++++++++
 rtl/pdp8_rfx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pdp8_rfx_pkg.sv
//==============================================================================
// Module  : pdp8_rfx_pkg
// Brief   : Shared types and constants for the RF08-style disk controller:
//           DMA state encoding, IOT sub-operation codes, status bit positions.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package pdp8_rfx_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WC_RD     = 3'd1,
    S_WC_WR     = 3'd2,
    S_CA_RD     = 3'd3,
    S_CA_WR     = 3'd4,
    S_XFER_DISK = 3'd5,
    S_XFER_MEM  = 3'd6,
    S_DONE      = 3'd7
  } dma_state_e;

  // Sub-operation codes carried in mb[2:0]
  localparam logic [2:0] OP_DCMA = 3'd1;  // base code
  localparam logic [2:0] OP_DMAR = 3'd3;
  localparam logic [2:0] OP_DMAW = 3'd5;
  localparam logic [2:0] OP_DIML = 3'd1;  // base + 1
  localparam logic [2:0] OP_DIMA = 3'd2;
  localparam logic [2:0] OP_DFSE = 3'd5;
  localparam logic [2:0] OP_DFSC = 3'd6;
  localparam logic [2:0] OP_LOCK = 3'd1;  // base + 4
  localparam logic [2:0] OP_DXAL = 3'd3;
  localparam logic [2:0] OP_DXAC = 3'd5;

  // Status word returned by DIMA
  localparam int STAT_DONE    = 11;
  localparam int STAT_NXD     = 10;
  localparam int STAT_WLS     = 9;
  localparam int STAT_BUSY    = 8;
  localparam int STAT_IEN     = 7;
  localparam int STAT_EMA_LSB = 4;

endpackage

`default_nettype wire

// File: rtl/pdp8_rfx_if.sv
//==============================================================================
// Module  : pdp8_rfx_if
// Brief   : CPU IOT bus, memory DMA port and disk port of the controller.
//           slave = controller side, master = CPU/memory/disk side.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

interface pdp8_rfx_if #(
  parameter int DA_W = 20
) ();
  logic            iot;
  logic [3:0]      state;
  logic [11:0]     mb;
  logic [5:0]      io_select;
  logic [11:0]     io_data_in;
  logic [11:0]     io_data_out;
  logic            io_data_avail;
  logic            io_skip;
  logic            io_interrupt;
  logic            ram_read_req;
  logic            ram_write_req;
  logic [14:0]     ram_ma;
  logic [11:0]     ram_out;
  logic            ram_done;
  logic [11:0]     ram_in;
  logic [DA_W-1:0] disk_addr;
  logic            disk_rd_req;
  logic            disk_wr_req;
  logic [11:0]     disk_out;
  logic            disk_done;
  logic [11:0]     disk_in;

  modport slave (
    input  iot, state, mb, io_select, io_data_in, ram_done, ram_in, disk_done, disk_in,
    output io_data_out, io_data_avail, io_skip, io_interrupt,
           ram_read_req, ram_write_req, ram_ma, ram_out,
           disk_addr, disk_rd_req, disk_wr_req, disk_out
  );

  modport master (
    output iot, state, mb, io_select, io_data_in, ram_done, ram_in, disk_done, disk_in,
    input  io_data_out, io_data_avail, io_skip, io_interrupt,
           ram_read_req, ram_write_req, ram_ma, ram_out,
           disk_addr, disk_rd_req, disk_wr_req, disk_out
  );
endinterface

`default_nettype wire

// File: rtl/pdp8_rfx_dma.sv
//==============================================================================
// Module  : pdp8_rfx_dma
// Brief   : Per-word DMA sequencer: bump WC and CA in field 0, then move one
//           word between disk and memory at {EMA, CA+1}. One request at a time.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module pdp8_rfx_dma
  import pdp8_rfx_pkg::*;
#(
  parameter logic [11:0] WC_ADDR = 12'o7750
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        dir_write,
  input  logic        abort,
  input  logic        nxd,
  input  logic        locked,
  input  logic [2:0]  ema,
  input  logic        ram_done,
  input  logic [11:0] ram_in,
  input  logic        disk_done,
  input  logic [11:0] disk_in,
  output logic        ram_read_req,
  output logic        ram_write_req,
  output logic [14:0] ram_ma,
  output logic [11:0] ram_out,
  output logic        disk_rd_req,
  output logic        disk_wr_req,
  output logic [11:0] disk_out,
  output logic        busy,
  output logic        dar_inc,
  output logic        set_done,
  output logic        set_nxd,
  output logic        set_wls
);

  localparam logic [14:0] WC_MA = {3'b000, WC_ADDR};
  localparam logic [14:0] CA_MA = {3'b000, WC_ADDR + 12'd1};

  dma_state_e  state_q, state_d;
  logic        req_q, req_d;
  logic        write_q, write_d;
  logic        wc_zero_q, wc_zero_d;
  logic [11:0] ca_q, ca_d;
  logic [14:0] ram_ma_q, ram_ma_d;
  logic [11:0] ram_out_q, ram_out_d;
  logic [11:0] disk_out_q, disk_out_d;

  // Sequencer state and registered bus outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      write_q    <= 1'b0;
      wc_zero_q  <= 1'b0;
      ca_q       <= 12'd0;
      ram_ma_q   <= 15'd0;
      ram_out_q  <= 12'd0;
      disk_out_q <= 12'd0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      write_q    <= write_d;
      wc_zero_q  <= wc_zero_d;
      ca_q       <= ca_d;
      ram_ma_q   <= ram_ma_d;
      ram_out_q  <= ram_out_d;
      disk_out_q <= disk_out_d;
    end
  end

  // Next state: a done response retires the current request and the new
  // state raises the next one; the word loop ends when the bumped WC is zero
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    write_d    = write_q;
    wc_zero_d  = wc_zero_q;
    ca_d       = ca_q;
    ram_ma_d   = ram_ma_q;
    ram_out_d  = ram_out_q;
    disk_out_d = disk_out_q;
    dar_inc    = 1'b0;
    set_done   = 1'b0;
    set_nxd    = 1'b0;
    set_wls    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        write_d  = dir_write;
        ram_ma_d = WC_MA;
        req_d    = 1'b1;
        state_d  = S_WC_RD;
      end
      S_WC_RD: if (ram_done) begin
        ram_out_d = ram_in + 12'd1;
        wc_zero_d = (ram_in == 12'o7777);
        state_d   = S_WC_WR;
      end
      S_WC_WR: if (ram_done) begin
        ram_ma_d = CA_MA;
        state_d  = S_CA_RD;
      end
      S_CA_RD: if (ram_done) begin
        ca_d      = ram_in + 12'd1;
        ram_out_d = ram_in + 12'd1;
        state_d   = S_CA_WR;
      end
      S_CA_WR: if (ram_done) begin
        ram_ma_d = {ema, ca_q};
        if (nxd) begin
          set_nxd = 1'b1;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (write_q && locked) begin
          set_wls = 1'b1;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = write_q ? S_XFER_MEM : S_XFER_DISK;
        end
      end
      S_XFER_DISK: if (disk_done) begin
        if (write_q) begin
          dar_inc  = 1'b1;
          ram_ma_d = WC_MA;
          req_d    = !wc_zero_q;
          state_d  = wc_zero_q ? S_DONE : S_WC_RD;
        end else begin
          ram_out_d = disk_in;
          state_d   = S_XFER_MEM;
        end
      end
      S_XFER_MEM: if (ram_done) begin
        if (write_q) begin
          disk_out_d = ram_in;
          state_d    = S_XFER_DISK;
        end else begin
          dar_inc  = 1'b1;
          ram_ma_d = WC_MA;
          req_d    = !wc_zero_q;
          state_d  = wc_zero_q ? S_DONE : S_WC_RD;
        end
      end
      S_DONE: begin
        set_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    // Clear-all from the CPU wins over everything in flight
    if (abort) begin
      state_d  = S_IDLE;
      req_d    = 1'b0;
      dar_inc  = 1'b0;
      set_done = 1'b0;
      set_nxd  = 1'b0;
      set_wls  = 1'b0;
    end
  end

  // Request strobes decoded from the registered state and request flag
  always_comb begin
    ram_read_req  = req_q && ((state_q == S_WC_RD) || (state_q == S_CA_RD) ||
                              ((state_q == S_XFER_MEM) && write_q));
    ram_write_req = req_q && ((state_q == S_WC_WR) || (state_q == S_CA_WR) ||
                              ((state_q == S_XFER_MEM) && !write_q));
    disk_rd_req   = req_q && (state_q == S_XFER_DISK) && !write_q;
    disk_wr_req   = req_q && (state_q == S_XFER_DISK) && write_q;
    busy          = (state_q != S_IDLE);
    ram_ma        = ram_ma_q;
    ram_out       = ram_out_q;
    disk_out      = disk_out_q;
  end

endmodule

`default_nettype wire

// File: rtl/pdp8_rfx.sv
//==============================================================================
// Module  : pdp8_rfx
// Brief   : RF08-style fixed-head disk controller for a PDP-8 IOT bus.
//           IOT decode, DAR/EMA/status registers; DMA in pdp8_rfx_dma.
//           Optional write-lock register: define PDP8_RFX_WLOCK_EN.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module pdp8_rfx
  import pdp8_rfx_pkg::*;
#(
  parameter logic [5:0]  DEV_CODE = 6'o60,
  parameter int          NDRIVES  = 4,
  parameter int          WPD_LOG2 = 18,
  parameter logic [11:0] WC_ADDR  = 12'o7750
) (
  input logic        clk,
  input logic        reset_n,
  pdp8_rfx_if.slave  bus
);

  localparam int DA_W  = $clog2(NDRIVES) + WPD_LOG2;
  // DAR always carries a full 3-bit drive field so out-of-range drives are visible
  localparam int DAR_W = WPD_LOG2 + 3;
  localparam int UP_W  = DAR_W - 12;
  localparam logic [3:0] NDRV = 4'(NDRIVES);

  logic [DAR_W-1:0] dar_q, dar_d;
  logic [2:0]       ema_q, ema_d;
  logic             ien_q, ien_d;
  logic             done_q, done_d;
  logic             nxd_q, nxd_d;
  logic             wls_q, wls_d;
  logic             iot_prev_q, iot_prev_d;

  logic        sel, fire, dev0, dev1, dev4;
  logic [2:0]  op;
  logic [2:0]  drive;
  logic        drive_nxd, locked;
  logic        start, dir_write, abort;
  logic        busy, dar_inc, set_done, set_nxd, set_wls;
  logic [11:0] status;
  logic        unused_mb;

  assign unused_mb = ^bus.mb[11:3];

  // IOT decode; the edge detect makes an IOT act once even if state 1 is held
  always_comb begin
    sel        = bus.iot && (bus.state == 4'h1);
    iot_prev_d = sel;
    fire       = sel && !iot_prev_q;
    op         = bus.mb[2:0];
    dev0       = sel && (bus.io_select == DEV_CODE);
    dev1       = sel && (bus.io_select == DEV_CODE + 6'd1);
    dev4       = sel && (bus.io_select == DEV_CODE + 6'd4);
    drive      = dar_q[DAR_W-1 -: 3];
    drive_nxd  = ({1'b0, drive} >= NDRV);
    status                       = 12'd0;
    status[STAT_DONE]            = done_q;
    status[STAT_NXD]             = nxd_q;
    status[STAT_WLS]             = wls_q;
    status[STAT_BUSY]            = busy;
    status[STAT_IEN]             = ien_q;
    status[STAT_EMA_LSB +: 3]    = ema_q;
  end

  // IOT responses, valid only while the decoded IOT is on the bus
  always_comb begin
    bus.io_data_out   = 12'd0;
    bus.io_data_avail = 1'b0;
    bus.io_skip       = 1'b0;
    if (dev1 && op == OP_DIMA) begin
      bus.io_data_out   = status;
      bus.io_data_avail = 1'b1;
    end
    if (dev1 && op == OP_DFSE) bus.io_skip = nxd_q || wls_q;
    if (dev1 && op == OP_DFSC) bus.io_skip = done_q;
    if (dev4 && op == OP_DXAC) begin
      bus.io_data_out   = 12'(dar_q[DAR_W-1:12]);
      bus.io_data_avail = 1'b1;
    end
    bus.io_interrupt = ien_q && (done_q || nxd_q || wls_q);
    bus.disk_addr    = dar_q[DA_W-1:0];
  end

  // Register updates from DMA events and IOT commands
  always_comb begin
    dar_d     = dar_q;
    ema_d     = ema_q;
    ien_d     = ien_q;
    done_d    = done_q;
    nxd_d     = nxd_q;
    wls_d     = wls_q;
    start     = 1'b0;
    dir_write = 1'b0;
    abort     = 1'b0;
    if (dar_inc)  dar_d  = dar_q + 1'b1;
    if (set_done) done_d = 1'b1;
    if (set_nxd)  nxd_d  = 1'b1;
    if (set_wls)  wls_d  = 1'b1;
    if (fire && dev0 && op == OP_DCMA) begin
      dar_d  = '0;
      done_d = 1'b0;
      nxd_d  = 1'b0;
      wls_d  = 1'b0;
      abort  = 1'b1;
    end
    if (fire && dev0 && (op == OP_DMAR || op == OP_DMAW) && !busy) begin
      dar_d[11:0] = bus.io_data_in;
      start       = 1'b1;
      dir_write   = (op == OP_DMAW);
    end
    if (fire && dev1 && op == OP_DIML) begin
      ien_d = bus.io_data_in[8];
      ema_d = bus.io_data_in[5:3];
    end
    if (fire && dev4 && op == OP_DXAL) dar_d[DAR_W-1:12] = bus.io_data_in[UP_W-1:0];
  end

  // Controller registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dar_q      <= '0;
      ema_q      <= 3'd0;
      ien_q      <= 1'b0;
      done_q     <= 1'b0;
      nxd_q      <= 1'b0;
      wls_q      <= 1'b0;
      iot_prev_q <= 1'b0;
    end else begin
      dar_q      <= dar_d;
      ema_q      <= ema_d;
      ien_q      <= ien_d;
      done_q     <= done_d;
      nxd_q      <= nxd_d;
      wls_q      <= wls_d;
      iot_prev_q <= iot_prev_d;
    end
  end

`ifdef PDP8_RFX_WLOCK_EN
  logic [NDRIVES-1:0] lock_q, lock_d;

  // Per-drive write lock, loaded as a whole by the lock IOT
  always_comb begin
    lock_d = lock_q;
    if (fire && dev4 && op == OP_LOCK) lock_d = bus.io_data_in[NDRIVES-1:0];
    locked = 1'b0;
    for (int i = 0; i < NDRIVES; i++) begin
      if (drive == 3'(i)) locked = lock_q[i];
    end
  end

  // Write-lock register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lock_q <= '0;
    else          lock_q <= lock_d;
  end
`else
  assign locked = 1'b0;
`endif

  pdp8_rfx_dma #(
    .WC_ADDR (WC_ADDR)
  ) u_dma (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .dir_write     (dir_write),
    .abort         (abort),
    .nxd           (drive_nxd),
    .locked        (locked),
    .ema           (ema_q),
    .ram_done      (bus.ram_done),
    .ram_in        (bus.ram_in),
    .disk_done     (bus.disk_done),
    .disk_in       (bus.disk_in),
    .ram_read_req  (bus.ram_read_req),
    .ram_write_req (bus.ram_write_req),
    .ram_ma        (bus.ram_ma),
    .ram_out       (bus.ram_out),
    .disk_rd_req   (bus.disk_rd_req),
    .disk_wr_req   (bus.disk_wr_req),
    .disk_out      (bus.disk_out),
    .busy          (busy),
    .dar_inc       (dar_inc),
    .set_done      (set_done),
    .set_nxd       (set_nxd),
    .set_wls       (set_wls)
  );

endmodule

`default_nettype wire
